// File: rtl/clk_int_even_divider.sv
// Even, programmable 50%-duty clock divider with runt-free ratio reload at full-period boundaries.
// Optional CLK_INT_DIV_ZERO_GATE_EN: an accepted ratio of 0 gates clk_o low until a non-zero ratio arrives.
`timescale 1ns/1ps

module dffr #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

endmodule

module clk_int_even_divider #(
  parameter int unsigned DIV_WIDTH = 32,
  parameter int unsigned DEF_DIV   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 div_done_o,
  output logic                 clk_o
);

  localparam logic [DIV_WIDTH-1:0] DEF = DIV_WIDTH'(DEF_DIV);
  localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] TWO = DIV_WIDTH'(2);

  logic [DIV_WIDTH-1:0] active_enc_q, active_enc_d;
  logic [DIV_WIDTH-1:0] pend_q, pend_d;
  logic [DIV_WIDTH-1:0] count_q, count_d;
  logic                 pending_q, pending_d;
  logic                 div_clk_q, div_clk_d;
  logic                 done_q, done_d;

  logic [DIV_WIDTH-1:0] active, half, sane;
  logic                 transfer, wrap, gated;

  // The active ratio is stored XORed with DEF_DIV so the reset-to-zero flop reads back as DEF_DIV.
  assign active   = active_enc_q ^ DEF;
  assign half     = active >> 1;
  assign wrap     = (count_q == (half - ONE));
  assign transfer = div_valid_i && div_ready_o;

`ifdef CLK_INT_DIV_ZERO_GATE_EN
  assign gated = (active == '0);
`else
  assign gated = 1'b0;
`endif

  always_comb begin
    sane = div_i & ~ONE;
    if (sane == '0) sane = TWO;
`ifdef CLK_INT_DIV_ZERO_GATE_EN
    if (div_i == '0) sane = '0;
`endif
  end

  always_comb begin
    active_enc_d = active_enc_q;
    pend_d       = pend_q;
    pending_d    = pending_q;
    count_d      = count_q + ONE;
    div_clk_d    = div_clk_q;
    done_d       = 1'b0;

    if (gated) begin
      count_d   = '0;
      div_clk_d = 1'b0;
      // While gated there is no period boundary to wait for, so a new ratio takes effect at once.
      if (transfer) begin
        active_enc_d = sane ^ DEF;
        done_d       = 1'b1;
      end
    end else begin
      if (wrap) begin
        count_d   = '0;
        div_clk_d = ~div_clk_q;
        if (div_clk_q && pending_q) begin
          active_enc_d = pend_q ^ DEF;
          pending_d    = 1'b0;
          done_d       = 1'b1;
        end
      end
      if (transfer) begin
        pend_d    = sane;
        pending_d = 1'b1;
      end
    end
  end

  dffr #(.WIDTH(DIV_WIDTH)) u_active  (.clk(clk_i), .rst_n(rst_n_i), .d(active_enc_d), .q(active_enc_q));
  dffr #(.WIDTH(DIV_WIDTH)) u_pend    (.clk(clk_i), .rst_n(rst_n_i), .d(pend_d),       .q(pend_q));
  dffr #(.WIDTH(DIV_WIDTH)) u_count   (.clk(clk_i), .rst_n(rst_n_i), .d(count_d),      .q(count_q));
  dffr #(.WIDTH(1))         u_pending (.clk(clk_i), .rst_n(rst_n_i), .d(pending_d),    .q(pending_q));
  dffr #(.WIDTH(1))         u_div_clk (.clk(clk_i), .rst_n(rst_n_i), .d(div_clk_d),    .q(div_clk_q));
  dffr #(.WIDTH(1))         u_done    (.clk(clk_i), .rst_n(rst_n_i), .d(done_d),       .q(done_q));

  assign div_ready_o = ~pending_q;
  assign div_done_o  = done_q;
  assign clk_o       = div_clk_q;

endmodule

// File: tb/tb_clk_int_even_divider.sv
// Directed bench for clk_int_even_divider: reset, reloads, sanitising, done feedback, mid-update reset.
// Expected clk_o/done/ready sequences are hand-derived bit strings, first sample in the MSB.
`timescale 1ns/1ps

module tb_clk_int_even_divider;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [31:0] div_i = 32'd0;
  logic        div_valid_i = 1'b0;
  logic        div_ready_o;
  logic        div_done_o;
  logic        clk_o;

  int checks = 0;
  int failures = 0;

  clk_int_even_divider #(.DIV_WIDTH(32), .DEF_DIV(4)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .div_i       (div_i),
    .div_valid_i (div_valid_i),
    .div_ready_o (div_ready_o),
    .div_done_o  (div_done_o),
    .clk_o       (clk_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic runCycles(input int n, output logic [63:0] clk_v, output logic [63:0] done_v,
                           output logic [63:0] ready_v);
    clk_v = '0;
    done_v = '0;
    ready_v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      clk_v   = {clk_v[62:0], clk_o};
      done_v  = {done_v[62:0], div_done_o};
      ready_v = {ready_v[62:0], div_ready_o};
    end
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] value, input logic exp_ready);
    div_i = value;
    div_valid_i = 1'b1;
    @(negedge clk_i);
    div_valid_i = 1'b0;
    checkOutput({tag, "_ready_after"}, 64'(div_ready_o), 64'(exp_ready));
  endtask

  // Entered one sample after the transfer edge; lat counts samples until done is seen.
  task automatic waitDone(input string tag, input int bound);
    int lat;
    lat = 1;
    while (div_done_o !== 1'b1 && lat < 64) begin
      @(negedge clk_i);
      lat++;
    end
    checkOutput({tag, "_done_seen"}, 64'(div_done_o), 64'd1);
    checkOutput({tag, "_latency_ok"}, 64'(lat <= bound), 64'd1);
  endtask

  task automatic checkUpdate(input string tag, input logic [31:0] value, input logic exp_ready,
                             input int old_ratio, input logic [63:0] exp_clk);
    logic [63:0] cv, dv, rv;
    applyStimulus(tag, value, exp_ready);
    waitDone(tag, old_ratio + 1);
    checkOutput({tag, "_clk_at_done"}, 64'(clk_o), 64'd0);
    runCycles(12, cv, dv, rv);
    checkOutput({tag, "_clk_pattern"}, cv, exp_clk);
    checkOutput({tag, "_done_quiet"}, dv, 64'd0);
    checkOutput({tag, "_ready_high"}, rv, 64'hFFF);
  endtask

  initial begin
    logic [63:0] cv, dv, rv;
    logic prev_done;

    repeat (40) @(negedge clk_i);
    checkOutput("reset_clk", 64'(clk_o), 64'd0);
    checkOutput("reset_ready", 64'(div_ready_o), 64'd1);
    checkOutput("reset_done", 64'(div_done_o), 64'd0);
    rst_n_i = 1'b1;

    runCycles(8, cv, dv, rv);
    checkOutput("def4_clk", cv, 64'b01100110);
    checkOutput("def4_done", dv, 64'd0);
    checkOutput("def4_ready", rv, 64'hFF);

    // Transfer 8 while clk_o is high; the old high phase must finish before the 4/4 pattern starts.
    repeat (2) @(negedge clk_i);
    checkOutput("pre8_high", 64'(clk_o), 64'd1);
    applyStimulus("div8", 32'd8, 1'b0);
    runCycles(12, cv, dv, rv);
    checkOutput("div8_clk", cv, 64'b000011110000);
    checkOutput("div8_done", dv, 64'b100000000000);
    checkOutput("div8_ready", rv, 64'hFFF);

    checkUpdate("div7", 32'd7, 1'b0, 8, 64'b001110001110);
    checkUpdate("div1", 32'd1, 1'b0, 6, 64'b101010101010);
`ifdef CLK_INT_DIV_ZERO_GATE_EN
    checkUpdate("div0_gate", 32'd0, 1'b0, 2, 64'd0);
    checkUpdate("div4_ungate", 32'd4, 1'b1, 2, 64'b011001100110);
`else
    checkUpdate("div0", 32'd0, 1'b0, 2, 64'b101010101010);
`endif

    applyStimulus("fb_start", 32'd4, 1'b0);
    waitDone("fb_start", 5);
    prev_done = div_done_o;
    cv = '0;
    dv = '0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      cv = {cv[62:0], clk_o};
      dv = {dv[62:0], div_done_o};
      div_valid_i = prev_done;
      prev_done = div_done_o;
    end
    div_valid_i = 1'b0;
    checkOutput("fb_clk", cv, 64'h6666666666666666);
    checkOutput("fb_done", dv, 64'h1111111111111111);

    applyStimulus("div16", 32'd16, 1'b0);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    checkOutput("midrst_clk", 64'(clk_o), 64'd0);
    checkOutput("midrst_ready", 64'(div_ready_o), 64'd1);
    checkOutput("midrst_done", 64'(div_done_o), 64'd0);
    runCycles(12, cv, dv, rv);
    checkOutput("midrst_clk_pattern", cv, 64'b011001100110);
    checkOutput("midrst_done_quiet", dv, 64'd0);
    checkOutput("midrst_ready_high", rv, 64'hFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
